// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// elaboration-time legality check for the WIDTH/DIGIT pairing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MIN_DIGIT = 1;

    // A digit must be at least one bit and must tile the operand exactly.
    function automatic bit digit_ok(input int width, input int digit);
        return (digit >= MIN_DIGIT) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the serial adder ripples DIGIT of these per step.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y ^ cin;
    assign carry = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: consumes DIGIT bits of each operand per clock and
// publishes sum/cout/overflow together with a one-cycle done pulse.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = (DIGIT >= MIN_DIGIT) ? (WIDTH / DIGIT) : 1;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (!digit_ok(WIDTH, DIGIT)) begin : g_illegal
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
    end

    state_e           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT-1:0] step_sum;
    logic [DIGIT:0]   chain;
    logic [WIDTH-1:0] sum_shift;

    assign chain[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_ripple
        full_adder u_fa (
            .x     (a_q[i]),
            .y     (b_q[i]),
            .cin   (chain[i]),
            .sum   (step_sum[i]),
            .carry (chain[i+1])
        );
    end

    // New digit enters at the top; after STEPS shifts the LSB digit is at bit 0.
    assign sum_shift = WIDTH'({step_sum, sum_q} >> DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    sum_q   <= sum_shift;
                    carry_q <= chain[DIGIT];
                    // Counter is held on the last step so it never wraps.
                    if (cnt_q == LAST) begin
                        sum      <= sum_shift;
                        cout     <= chain[DIGIT];
                        overflow <= chain[DIGIT-1] ^ chain[DIGIT];
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a bit-serial (8/1) and a nibble-serial
// (16/4) instance driven from one clock, checked against hand-computed results.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;

    logic        start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected results as {cout, overflow, sum[15:0]}.
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start8),
        .a        (a8),
        .b        (b8),
        .cin      (cin8),
        .busy     (busy8),
        .done     (done8),
        .sum      (sum8),
        .cout     (cout8),
        .overflow (ovf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start16),
        .a        (a16),
        .b        (b16),
        .cin      (cin16),
        .busy     (busy16),
        .done     (done16),
        .sum      (sum16),
        .cout     (cout16),
        .overflow (ovf16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge. Latency is counted in negedge samples
    // from the accepting edge, so done seen on sample STEPS+1 is on time.
    task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [17:0] exp, input int lat,
                          input string tag);
        int          n;
        logic [17:0] e;
        logic [17:0] got;
        exp_q.push_back(exp);
        if (wide) begin
            a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; cin8 = c; start8 = 1'b1;
        end
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16;
        n = 1;
        check({tag, "_busy"}, wide ? busy16 : busy8, 1);
        while (!(wide ? done16 : done8) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, lat);
        e   = exp_q.pop_front();
        got = wide ? {cout16, ovf16, sum16} : {cout8, ovf8, 8'h00, sum8};
        check({tag, "_result"}, got, e);
        @(negedge clk);
        check({tag, "_done_pulse"}, wide ? done16 : done8, 0);
        check({tag, "_idle"}, wide ? busy16 : busy8, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        int first;
        logic [17:0] res;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_out8", {cout8, ovf8, sum8}, 0);
        check("rst_busy16", busy16, 0);
        check("rst_out16", {done16, cout16, ovf16, sum16}, 0);

        // Start on the very first edge after reset release.
        rst_n = 1'b1;
        run_op(0, 16'h3C, 16'h5A, 1'b0, {1'b0, 1'b1, 16'h0096}, 9, "add_3c_5a");
        run_op(0, 16'hFF, 16'h01, 1'b0, {1'b1, 1'b0, 16'h0000}, 9, "add_ff_01");
        run_op(0, 16'hFF, 16'hFF, 1'b1, {1'b1, 1'b0, 16'h00FF}, 9, "add_ff_ff_c");
        run_op(0, 16'h7F, 16'h01, 1'b0, {1'b0, 1'b1, 16'h0080}, 9, "add_7f_01");
        run_op(0, 16'h80, 16'h80, 1'b0, {1'b1, 1'b1, 16'h0000}, 9, "add_80_80");
        run_op(0, 16'h00, 16'h00, 1'b1, {1'b0, 1'b0, 16'h0001}, 9, "add_00_00_c");
        check("hold_idle", {cout8, ovf8, sum8}, {2'b00, 8'h01});

        // Second start during RUN cycle 3 must be ignored.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_run", sum8, 8'h01);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pulses = 0; first = 0; res = '0;
        for (int n = 4; n <= 24; n++) begin
            if (done8) begin
                pulses++;
                if (pulses == 1) begin
                    first = n;
                    res   = {cout8, ovf8, 8'h00, sum8};
                end
            end
            @(negedge clk);
        end
        check("restart_pulses", pulses, 1);
        check("restart_latency", first, 9);
        check("restart_result", res, {1'b0, 1'b0, 16'h0046});

        // Reset asserted in RUN cycle 4 aborts the addition.
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_outputs", {done8, cout8, ovf8, sum8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            if (done8) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 0);
        run_op(0, 16'h3C, 16'h5A, 1'b0, {1'b0, 1'b1, 16'h0096}, 9, "after_abort");

        // Nibble-serial instance: four steps per addition.
        run_op(1, 16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h0000}, 5, "w16_ffff_0001");
        run_op(1, 16'h7FFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h8000}, 5, "w16_7fff_0001");
        run_op(1, 16'h1234, 16'h4321, 1'b1, {1'b0, 1'b0, 16'h5556}, 5, "w16_1234_4321_c");
        run_op(1, 16'h8000, 16'hFFFF, 1'b0, {1'b1, 1'b1, 16'h7FFF}, 5, "w16_8000_ffff");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
